// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and constants for the bit-serial adder.
//   state_t      - FSM state encoding (S_IDLE, S_RUN, S_DONE)
//   cnt_width()  - bit counter width, max(1, clog2(width))
//   WIDTH_MIN/MAX - legal operand width range
package serial_adder_pkg;

   localparam int unsigned WIDTH_MIN = 1;
   localparam int unsigned WIDTH_MAX = 64;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // A 1-bit counter is still needed when width is 1 (clog2(1) == 0).
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit combinational full-adder cell.
//   A, B, CI - addend bits and carry-in
//   S, CO    - sum bit and carry-out
module full_adder (
   input  logic A,
   input  logic B,
   input  logic CI,
   output logic S,
   output logic CO
);

   assign S  = A ^ B ^ CI;
   assign CO = (A & B) | (A & CI) | (B & CI);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: WIDTH-bit adder processed LSB-first, one bit per clock,
// through a single full_adder cell and a carry flop.
//   CLK, RST        - clock, synchronous active-high reset
//   START           - request, sampled only in idle
//   A, B, CI        - operands and carry-in, latched on accepted START
//   SUB             - subtract select (only with SERIAL_ADDER_SUB_EN defined)
//   BUSY            - high while bits are being processed
//   DONE            - one-cycle pulse when S/CO become valid
//   S, CO           - registered result, held until the next completion
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds SUB, two's-complement subtract).
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CI,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             SUB,
`endif
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] S,
   output logic             CO
);

   localparam int unsigned CW = cnt_width(WIDTH);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("serial_adder: WIDTH out of legal range");
   end

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             co_q, co_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             b_bit;
   logic             fa_s;
   logic             fa_co;
   logic             ci_init;

`ifdef SERIAL_ADDER_SUB_EN
   logic sub_q, sub_d;

   // Subtraction: invert B bits and the initial carry.
   assign b_bit   = b_q[0] ^ sub_q;
   assign ci_init = CI ^ SUB;
`else
   assign b_bit   = b_q[0];
   assign ci_init = CI;
`endif

   full_adder u_full_adder (
      .A  (a_q[0]),
      .B  (b_bit),
      .CI (carry_q),
      .S  (fa_s),
      .CO (fa_co)
   );

   // State and datapath registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         s_q     <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         co_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
         sub_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         s_q     <= s_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         co_q    <= co_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef SERIAL_ADDER_SUB_EN
         sub_q   <= sub_d;
`endif
      end
   end

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      s_d     = s_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      co_d    = co_q;
`ifdef SERIAL_ADDER_SUB_EN
      sub_d   = sub_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (START) begin
               a_d     = A;
               b_d     = B;
               carry_d = ci_init;
               cnt_d   = '0;
`ifdef SERIAL_ADDER_SUB_EN
               sub_d   = SUB;
`endif
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // Shift-based forms stay legal for WIDTH == 1.
            sum_d   = (sum_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = fa_co;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               s_d     = sum_d;
               co_d    = fa_co;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   assign BUSY = busy_q;
   assign DONE = done_q;
   assign S    = s_q;
   assign CO   = co_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder (WIDTH=8), directed
// cases plus randomized operations against an arithmetic reference model.
module tb_serial_adder;

   localparam int unsigned W = 8;
`ifdef SERIAL_ADDER_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a, b, s;
   logic         ci, sub, busy, done, co;

   logic [W:0]   last_res;
   int           errors = 0;
   int           checks = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(W)) dut (
      .CLK   (clk),
      .RST   (rst),
      .START (start),
      .A     (a),
      .B     (b),
      .CI    (ci),
`ifdef SERIAL_ADDER_SUB_EN
      .SUB   (sub),
`endif
      .BUSY  (busy),
      .DONE  (done),
      .S     (s),
      .CO    (co)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // {CO,S} = A + B' + carry0, where B' and carry0 follow the subtract rule.
   function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                        input logic mci, input logic msub);
      logic         sb;
      logic [W-1:0] bb;
      sb = SUB_EN ? msub : 1'b0;
      bb = sb ? ~mb : mb;
      return (W+1)'(ma) + (W+1)'(bb) + (W+1)'(mci ^ sb);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for DONE, check result, then step into idle.
   task automatic wait_done(input string tag, input logic [W:0] exp);
      bit seen = 1'b0;
      for (int i = 0; i < 3 * W; i++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      check({tag, " done_seen"}, 64'(seen), 64'd1);
      check({tag, " result"}, 64'({co, s}), 64'(exp));
      last_res = exp;
      tick();
   endtask

   // Full operation with timing checks; caller is 1ns after an edge in idle.
   task automatic run_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                         input logic oci, input logic osub, input bit spam);
      logic [W:0] exp;
      int busy_n = 0, done_n = 0, done_at = -1;
      bit overlap = 1'b0;
      exp   = model(oa, ob, oci, osub);
      a     = oa;
      b     = ob;
      ci    = oci;
      sub   = osub;
      start = 1'b1;
      tick();
      if (spam) begin
         a = 8'h11;
         b = 8'h22;
      end else begin
         start = 1'b0;
         a     = W'($urandom);
         b     = W'($urandom);
      end
      check({tag, " held_at_accept"}, 64'({co, s}), 64'(last_res));
      for (int n = 0; n <= W + 1; n++) begin
         if (busy) busy_n++;
         if (done) begin
            done_n++;
            done_at = n;
         end
         if (busy && done) overlap = 1'b1;
         if (n < W + 1) tick();
      end
      check({tag, " busy_cycles"}, 64'(busy_n), 64'(W));
      check({tag, " done_latency"}, 64'(done_at), 64'(W));
      check({tag, " done_count"}, 64'(done_n), 64'd1);
      check({tag, " busy_done_overlap"}, 64'(overlap), 64'd0);
      check({tag, " result"}, 64'({co, s}), 64'(exp));
      last_res = exp;
      if (spam) begin
         tick();
         start = 1'b0;
         check({tag, " reaccept_busy"}, 64'(busy), 64'd1);
         wait_done({tag, " follow"}, model(8'h11, 8'h22, oci, osub));
      end
   endtask

   initial begin
      int changes;
      int dones;
      rst      = 1'b1;
      start    = 1'b0;
      a        = '0;
      b        = '0;
      ci       = 1'b0;
      sub      = 1'b0;
      last_res = '0;
      tick();
      tick();
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset s", 64'(s), 64'd0);
      check("reset co", 64'(co), 64'd0);
      rst = 1'b0;
      tick();

      run_op("zero", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      run_op("ff+01", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
      run_op("5a+a5+1", 8'h5A, 8'hA5, 1'b1, 1'b0, 1'b0);
      run_op("5a+a5", 8'h5A, 8'hA5, 1'b0, 1'b0, 1'b0);
      run_op("spam", 8'h03, 8'h04, 1'b0, 1'b0, 1'b1);

      // Abort in the fourth BUSY cycle.
      a     = 8'hF0;
      b     = 8'h0F;
      ci    = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort busy", 64'(busy), 64'd0);
      check("abort result", 64'({co, s}), 64'd0);
      dones = 0;
      for (int i = 0; i < 2 * W; i++) begin
         if (done) dones++;
         tick();
      end
      check("abort no_done", 64'(dones), 64'd0);
      last_res = '0;
      run_op("after_abort", 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);

      run_op("hold_op", 8'h10, 8'h20, 1'b0, 1'b0, 1'b0);
      changes = 0;
      for (int i = 0; i < 20; i++) begin
         if ({co, s} !== last_res) changes++;
         tick();
      end
      check("hold changes", 64'(changes), 64'd0);
      check("hold s", 64'(s), 64'h30);

      if (SUB_EN) begin
         run_op("sub 10-20", 8'h10, 8'h20, 1'b0, 1'b1, 1'b0);
         check("sub 10-20 direct", 64'({co, s}), 64'h0F0);
         run_op("sub 20-10", 8'h20, 8'h10, 1'b0, 1'b1, 1'b0);
         check("sub 20-10 direct", 64'({co, s}), 64'h110);
         run_op("nosub 10+20", 8'h10, 8'h20, 1'b0, 1'b0, 1'b0);
         check("nosub direct", 64'({co, s}), 64'h030);
      end

      for (int i = 0; i < 25; i++) begin
         run_op($sformatf("rand%0d", i), W'($urandom), W'($urandom),
                1'($urandom), 1'($urandom), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
